// File: rtl/alu_nibble_seq_pkg.sv
// Shared constants for the nibble-serial ALU sequencer: opcodes, FSM state
// encoding and the 4-bit slice select encodings.
package alu_nibble_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBB  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // {s1, s0} as seen by the slice: x + sel + cin
  localparam logic [1:0] SEL_Y    = 2'b00;
  localparam logic [1:0] SEL_NY   = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;
  localparam logic [1:0] SEL_ONES = 2'b11;

endpackage

// File: rtl/alu_nibble_seq_decode.sv
// Opcode decoder: maps the request opcode and carry-in onto the slice select
// lines and the carry fed into nibble 0. Purely combinational.
module alu_seq_decode
  import alu_nibble_seq_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic       cin_i,
  output logic       s1_o,
  output logic       s0_o,
  output logic       cin0_o
);

  logic [1:0] sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    sel    = SEL_ZERO;
    cin0_o = 1'b0;
    case (op_i)
      OP_ADD:  begin sel = SEL_Y;    cin0_o = 1'b0;  end
      OP_ADC:  begin sel = SEL_Y;    cin0_o = cin_i; end
      OP_SUB:  begin sel = SEL_NY;   cin0_o = 1'b1;  end
      OP_SBB:  begin sel = SEL_NY;   cin0_o = cin_i; end
      OP_INC:  begin sel = SEL_ZERO; cin0_o = 1'b1;  end
      OP_DEC:  begin sel = SEL_ONES; cin0_o = 1'b0;  end
      default: begin sel = SEL_ZERO; cin0_o = 1'b0;  end  // PASS and reserved
    endcase
  end

  assign {s1_o, s0_o} = sel;

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial add/sub/inc/dec/pass sequencer driving an external 4-bit slice.
// Optional zero/overflow result flags are enabled with `define ALU_SEQ_FLAGS_EN.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_x,
  input  logic [W-1:0] req_y,
  input  logic         req_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_d,
  output logic         rsp_cout,
`ifdef ALU_SEQ_FLAGS_EN
  output logic         rsp_zero,
  output logic         rsp_ovf,
`endif
  output logic [3:0]   alu_x,
  output logic [3:0]   alu_y,
  output logic         alu_cin,
  output logic         alu_s1,
  output logic         alu_s0,
  input  logic [3:0]   alu_d,
  input  logic         alu_cout
);

  localparam int            KW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          c_q, c_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic [1:0]    sel_q, sel_d;
  logic          cin0_q, cin0_d;
  logic [W-1:0]  rsp_d_q, rsp_d_d;
  logic          rsp_cout_q, rsp_cout_d;

  logic dec_s1, dec_s0, dec_cin0;

  alu_seq_decode u_decode (
    .op_i   (req_op),
    .cin_i  (req_cin),
    .s1_o   (dec_s1),
    .s0_o   (dec_s0),
    .cin0_o (dec_cin0)
  );

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, zero_d, ovf_q, ovf_d;
  logic sel_msb;

  always_comb begin
    case (sel_q)
      SEL_Y:    sel_msb = y_q[W-1];
      SEL_NY:   sel_msb = ~y_q[W-1];
      SEL_ZERO: sel_msb = 1'b0;
      default:  sel_msb = 1'b1;
    endcase
  end
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    c_d        = c_q;
    x_d        = x_q;
    y_d        = y_q;
    sel_d      = sel_q;
    cin0_d     = cin0_q;
    rsp_d_d    = rsp_d_q;
    rsp_cout_d = rsp_cout_q;
`ifdef ALU_SEQ_FLAGS_EN
    zero_d     = zero_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          x_d     = req_x;
          y_d     = req_y;
          sel_d   = {dec_s1, dec_s0};
          cin0_d  = dec_cin0;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rsp_d_d[{k_q, 2'b00} +: 4] = alu_d;
        c_d = alu_cout;
        if (k_q == K_LAST) begin
          rsp_cout_d = alu_cout;
          k_d        = '0;
          state_d    = ST_DONE;
`ifdef ALU_SEQ_FLAGS_EN
          zero_d     = (rsp_d_d == '0);
          ovf_d      = (x_q[W-1] == sel_msb) && (alu_d[3] != x_q[W-1]);
`endif
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      c_q        <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      sel_q      <= SEL_Y;
      cin0_q     <= 1'b0;
      rsp_d_q    <= '0;
      rsp_cout_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      c_q        <= c_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sel_q      <= sel_d;
      cin0_q     <= cin0_d;
      rsp_d_q    <= rsp_d_d;
      rsp_cout_q <= rsp_cout_d;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  // The slice pins idle at zero so a shared slice sees no activity outside RUN.
  always_comb begin
    alu_x   = 4'h0;
    alu_y   = 4'h0;
    alu_cin = 1'b0;
    alu_s1  = 1'b0;
    alu_s0  = 1'b0;
    if (state_q == ST_RUN) begin
      alu_x            = x_q[{k_q, 2'b00} +: 4];
      alu_y            = y_q[{k_q, 2'b00} +: 4];
      {alu_s1, alu_s0} = sel_q;
      alu_cin          = (k_q == '0) ? cin0_q : c_q;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_d     = rsp_d_q;
  assign rsp_cout  = rsp_cout_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign rsp_zero  = zero_q;
  assign rsp_ovf   = ovf_q;
`endif

endmodule
